// File: rtl/reg_writeback_queue.sv
// Purpose: in-order writeback queue merging ALU and load write requests onto a single register-file write port.
// Latency: a request accepted at posedge N drives REG_WE low from posedge N+1 when the queue was empty; the register file captures it at the following negedge.
// Backpressure: the Readys are combinational from the pre-edge Count, with ALU priority for the last free slot; a same-cycle pop is not credited.
//
// Ports:
//   Clk, Reset               clock (posedge) and async active-high reset
//   ALU_Valid/Dst/Data/Ready ALU producer handshake
//   LD_Valid/Dst/Data/Ready  load producer handshake
//   REG_WE/REG_Dst/DIn       registered register-file write port (REG_WE active low)
//   Pending                  per-register mask of queued or issuing writes
//   Count                    occupied queue entries
module reg_writeback_queue #(
  parameter int DataWidth  = 8,
  parameter int SelectSize = 3,
  parameter int Depth      = 4,
  parameter int PtrSize    = 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        ALU_Valid,
  input  logic [SelectSize-1:0]       ALU_Dst,
  input  logic [DataWidth-1:0]        ALU_Data,
  output logic                        ALU_Ready,
  input  logic                        LD_Valid,
  input  logic [SelectSize-1:0]       LD_Dst,
  input  logic [DataWidth-1:0]        LD_Data,
  output logic                        LD_Ready,
  output logic                        REG_WE,
  output logic [SelectSize-1:0]       REG_Dst,
  output logic [DataWidth-1:0]        DIn,
  output logic [(1<<SelectSize)-1:0]  Pending,
  output logic [PtrSize:0]            Count
);

  localparam int NumRegs = 1 << SelectSize;
  localparam logic [PtrSize:0] DepthC  = (PtrSize+1)'(Depth);
  localparam logic [PtrSize:0] DepthM1 = (PtrSize+1)'(Depth - 1);

  logic [SelectSize-1:0] dst_q [Depth];
  logic [SelectSize-1:0] dst_d [Depth];
  logic [DataWidth-1:0]  dat_q [Depth];
  logic [DataWidth-1:0]  dat_d [Depth];
  logic [PtrSize-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrSize-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrSize:0]      count_q, count_d;
  logic                  reg_we_q, reg_we_d;
  logic [SelectSize-1:0] reg_dst_q, reg_dst_d;
  logic [DataWidth-1:0]  din_q, din_d;

  logic alu_fire, ld_fire, pop;

  // The load path only gets the last free slot when the ALU is not asking for it.
  assign ALU_Ready = (count_q < DepthC);
  assign LD_Ready  = (count_q < DepthM1) | ((count_q < DepthC) & ~ALU_Valid);

  assign alu_fire = ALU_Valid & ALU_Ready;
  assign ld_fire  = LD_Valid & LD_Ready;
  assign pop      = (count_q != '0);

  always_comb begin
    logic [PtrSize-1:0] ld_slot;
    dst_d     = dst_q;
    dat_d     = dat_q;
    rd_ptr_d  = rd_ptr_q;
    reg_we_d  = 1'b1;
    reg_dst_d = reg_dst_q;
    din_d     = din_q;

    if (pop) begin
      reg_we_d  = 1'b0;
      reg_dst_d = dst_q[rd_ptr_q];
      din_d     = dat_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PtrSize'(1);
    end

    // ALU entry goes in first so a simultaneous load lands behind it.
    if (alu_fire) begin
      dst_d[wr_ptr_q] = ALU_Dst;
      dat_d[wr_ptr_q] = ALU_Data;
    end
    ld_slot = wr_ptr_q + PtrSize'(alu_fire);
    if (ld_fire) begin
      dst_d[ld_slot] = LD_Dst;
      dat_d[ld_slot] = LD_Data;
    end

    wr_ptr_d = wr_ptr_q + PtrSize'(alu_fire) + PtrSize'(ld_fire);
    count_d  = count_q + (PtrSize+1)'(alu_fire) + (PtrSize+1)'(ld_fire)
             - (PtrSize+1)'(pop);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < Depth; i++) begin
        dst_q[i] <= '0;
        dat_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      reg_we_q  <= 1'b1;
      reg_dst_q <= '0;
      din_q     <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        dst_q[i] <= dst_d[i];
        dat_q[i] <= dat_d[i];
      end
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      reg_we_q  <= reg_we_d;
      reg_dst_q <= reg_dst_d;
      din_q     <= din_d;
    end
  end

  // An entry is live when its distance from the read pointer is below Count;
  // the write currently on the port still counts as pending.
  always_comb begin
    logic [PtrSize-1:0] off;
    Pending = '0;
    for (int i = 0; i < Depth; i++) begin
      off = PtrSize'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        Pending = Pending | (NumRegs'(1) << dst_q[i]);
      end
    end
    if (!reg_we_q) begin
      Pending = Pending | (NumRegs'(1) << reg_dst_q);
    end
  end

  assign REG_WE  = reg_we_q;
  assign REG_Dst = reg_dst_q;
  assign DIn     = din_q;
  assign Count   = count_q;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a queue-based model checked every cycle plus literal spot checks.
module tb_reg_writeback_queue;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ALU_Valid = 1'b0;
  logic [2:0] ALU_Dst = '0;
  logic [7:0] ALU_Data = '0;
  logic       ALU_Ready;
  logic       LD_Valid = 1'b0;
  logic [2:0] LD_Dst = '0;
  logic [7:0] LD_Data = '0;
  logic       LD_Ready;
  logic       REG_WE;
  logic [2:0] REG_Dst;
  logic [7:0] DIn;
  logic [7:0] Pending;
  logic [2:0] Count;

  reg_writeback_queue #(.DataWidth(8), .SelectSize(3), .Depth(4), .PtrSize(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .ALU_Valid(ALU_Valid), .ALU_Dst(ALU_Dst), .ALU_Data(ALU_Data), .ALU_Ready(ALU_Ready),
    .LD_Valid(LD_Valid), .LD_Dst(LD_Dst), .LD_Data(LD_Data), .LD_Ready(LD_Ready),
    .REG_WE(REG_WE), .REG_Dst(REG_Dst), .DIn(DIn), .Pending(Pending), .Count(Count)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an in-order list of accepted writes and the write on the port.
  logic [10:0] mq[$];
  logic        m_we = 1'b1;
  logic [2:0]  m_dst = '0;
  logic [7:0]  m_din = '0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq.delete();
      m_we = 1'b1; m_dst = '0; m_din = '0;
    end else begin
      int  cnt;
      bit  a_ok, l_ok;
      cnt  = mq.size();
      a_ok = cnt < 4;
      l_ok = (cnt < 3) || ((cnt < 4) && !ALU_Valid);
      if (cnt > 0) begin
        logic [10:0] e;
        e = mq.pop_front();
        m_we = 1'b0; m_dst = e[10:8]; m_din = e[7:0];
      end else begin
        m_we = 1'b1;
      end
      if (ALU_Valid && a_ok) mq.push_back({ALU_Dst, ALU_Data});
      if (LD_Valid && l_ok)  mq.push_back({LD_Dst, LD_Data});
    end
  end

  function automatic logic [7:0] model_pending();
    logic [7:0] p = '0;
    foreach (mq[i]) p[mq[i][10:8]] = 1'b1;
    if (!m_we) p[m_dst] = 1'b1;
    return p;
  endfunction

  always begin
    @(posedge Clk);
    #6;
    check("we", REG_WE, m_we);
    check("dst", REG_Dst, m_dst);
    check("din", DIn, m_din);
    check("count", Count, mq.size());
    check("pending", Pending, model_pending());
    check("alu_rdy", ALU_Ready, mq.size() < 4);
    check("ld_rdy", LD_Ready, (mq.size() < 3) || ((mq.size() < 4) && !ALU_Valid));
  end

  // Register file as the real one sees it: capture on negedge.
  logic [7:0] rf [8];
  int         n_writes = 0;
  always @(negedge Clk) begin
    if (!Reset && REG_WE == 1'b0) begin
      rf[REG_Dst] = DIn;
      n_writes++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int ld_idx;
    int wsnap;
    bit ld_go;
    repeat (3) tick();
    // Reset state
    check("t1_we", REG_WE, 1);
    check("t1_pend", Pending, 0);
    check("t1_cnt", Count, 0);
    check("t1_alu_rdy", ALU_Ready, 1);
    check("t1_ld_rdy", LD_Ready, 1);
    Reset = 1'b0;
    tick();

    // Single ALU write
    ALU_Valid = 1; ALU_Dst = 3'd3; ALU_Data = 8'hA5;
    tick();
    ALU_Valid = 0;
    check("t2_cnt_n", Count, 1);
    check("t2_we_n", REG_WE, 1);
    check("t2_pend_n", Pending, 8'h08);
    tick();
    check("t2_we", REG_WE, 0);
    check("t2_dst", REG_Dst, 3);
    check("t2_din", DIn, 8'hA5);
    check("t2_pend", Pending, 8'h08);
    tick();
    check("t2_we_end", REG_WE, 1);
    check("t2_pend_end", Pending, 0);

    // Simultaneous ALU and load
    ALU_Valid = 1; ALU_Dst = 3'd1; ALU_Data = 8'h11;
    LD_Valid = 1;  LD_Dst = 3'd2;  LD_Data = 8'h22;
    tick();
    ALU_Valid = 0; LD_Valid = 0;
    check("t3_cnt2", Count, 2);
    tick();
    check("t3_w1", {REG_WE, REG_Dst, DIn}, {1'b0, 3'd1, 8'h11});
    check("t3_cnt1", Count, 1);
    tick();
    check("t3_w2", {REG_WE, REG_Dst, DIn}, {1'b0, 3'd2, 8'h22});
    check("t3_cnt0", Count, 0);
    tick();
    check("t3_idle", REG_WE, 1);

    // Both producers streaming: ALU gets priority for the last slot
    ld_idx = 0;
    for (int c = 0; c < 8; c++) begin
      ALU_Valid = 1; ALU_Dst = 3'(c); ALU_Data = 8'(8'h40 + c);
      LD_Valid = 1;  LD_Dst = 3'(7 - (ld_idx % 8)); LD_Data = 8'(8'h80 + ld_idx);
      #1;
      if (c == 2) begin
        check("t4_cnt3", Count, 3);
        check("t4_ld_blk", LD_Ready, 0);
        check("t4_alu_ok", ALU_Ready, 1);
      end
      ld_go = LD_Ready;
      tick();
      if (ld_go) ld_idx++;
    end
    ALU_Valid = 0; LD_Valid = 0;
    repeat (5) tick();
    check("t4_drained", Count, 0);

    // Same register twice
    ALU_Valid = 1; ALU_Dst = 3'd5; ALU_Data = 8'h01;
    LD_Valid = 1;  LD_Dst = 3'd5;  LD_Data = 8'h02;
    tick();
    ALU_Valid = 0; LD_Valid = 0;
    tick();
    check("t5_w1", {REG_Dst, DIn}, {3'd5, 8'h01});
    check("t5_p1", Pending[5], 1);
    tick();
    check("t5_w2", {REG_Dst, DIn}, {3'd5, 8'h02});
    check("t5_p2", Pending[5], 1);
    tick();
    check("t5_p_clr", Pending[5], 0);
    check("t5_rf", rf[5], 8'h02);

    // Asynchronous reset while draining
    ALU_Valid = 1; ALU_Dst = 3'd4; ALU_Data = 8'hC4;
    LD_Valid = 1;  LD_Dst = 3'd6;  LD_Data = 8'hC6;
    tick();
    ALU_Data = 8'hD4; LD_Data = 8'hD6;
    tick();
    ALU_Valid = 0; LD_Valid = 0;
    check("t6_cnt_pre", Count, 3);
    check("t6_we_pre", REG_WE, 0);
    #3;
    Reset = 1'b1;
    #1;
    check("t6_we_rst", REG_WE, 1);
    check("t6_cnt_rst", Count, 0);
    check("t6_pend_rst", Pending, 0);
    repeat (2) tick();
    Reset = 1'b0;
    wsnap = n_writes;
    repeat (4) tick();
    check("t6_no_writes", n_writes, wsnap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
